// File: rtl/acc_restore_up_pkg.sv
// Shared ALU-side definitions: FSM state encoding and default word width.
package proc_alu_pkg;
  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/acc_restore_up_if.sv
// Operand/result handshake bundle for the accumulator-restore unit.
interface acc_restore_up_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] rd_data;
  logic [W-1:0] diff_mag;
  logic         diff_neg;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] acc_out;
  logic         range_err;

  modport master (
    output in_valid, rd_data, diff_mag, diff_neg, out_ready,
    input  in_ready, out_valid, acc_out, range_err
  );

  modport slave (
    input  in_valid, rd_data, diff_mag, diff_neg, out_ready,
    output in_ready, out_valid, acc_out, range_err
  );
endinterface

// File: rtl/acc_restore_up_fa_bit_up.sv
// Combinational 1-bit full adder, the only arithmetic cell of the serial datapath.
module fa_bit_up (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/acc_restore_up.sv
// Bit-serial accumulator restore: acc = rd + mag (neg=0) or rd - mag (neg=1),
// one full-adder cell reused over W cycles, LSB first.
module acc_restore_up
  import proc_alu_pkg::*;
#(
  parameter  int W  = WORD_W,
  localparam int CW = $clog2(W)
) (
  input  logic              clk,
  input  logic              rst,
  acc_restore_up_if.slave   bus
);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t          r_state;
  logic [W-1:0]    r_rd_sr;
  logic [W-1:0]    r_mag_sr;
  logic [W-1:0]    r_res_sr;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_carry;
  logic            r_err;
  logic            r_out_valid;

  logic            w_b;
  logic            w_s;
  logic            w_cout;
  logic [W-1:0]    w_res_nxt;

  // Subtraction is rd + ~mag + 1: invert mag per bit, the +1 is the preloaded carry.
  assign w_b       = r_mag_sr[0] ^ r_neg;
  assign w_res_nxt = {w_s, r_res_sr[W-1:1]};

  fa_bit_up u_fa (
    .i_a    (r_rd_sr[0]),
    .i_b    (w_b),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rd_sr     <= '0;
      r_mag_sr    <= '0;
      r_res_sr    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_rd_sr  <= bus.rd_data;
            r_mag_sr <= bus.diff_mag;
            r_neg    <= bus.diff_neg;
            r_carry  <= bus.diff_neg;
            r_res_sr <= '0;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_carry  <= w_cout;
          r_res_sr <= w_res_nxt;
          r_rd_sr  <= {1'b0, r_rd_sr[W-1:1]};
          r_mag_sr <= {1'b0, r_mag_sr[W-1:1]};
          if (r_cnt == LAST) begin
            r_acc       <= w_res_nxt;
            // Adding: carry out means overflow. Subtracting: missing carry means borrow.
            r_err       <= w_cout ^ r_neg;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.acc_out   = r_acc;
  assign bus.range_err = r_err;
endmodule

// File: tb/tb_acc_restore_up.sv
// Directed bench for acc_restore_up: arithmetic cases, latency, backpressure,
// async reset mid-run and a subtractor round trip.
module tb_acc_restore_up;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  acc_restore_up_if #(.W(W)) bif ();

  acc_restore_up #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bif.in_ready !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 30) chk({tag, "_ready_timeout"}, 32'(bif.in_ready), 32'd1);
  endtask

  // Present operands for one edge, then scramble inputs so only captured copies matter.
  task automatic launch(input logic [W-1:0] rd, input logic [W-1:0] mag, input logic neg);
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.rd_data  = rd;
    bif.diff_mag = mag;
    bif.diff_neg = neg;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    bif.rd_data  = ~rd;
    bif.diff_mag = ~mag;
    bif.diff_neg = ~neg;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (bif.out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] rd, input logic [W-1:0] mag,
                    input logic neg, input logic [W-1:0] exp_acc, input logic exp_err);
    int cyc;
    wait_ready(tag);
    launch(rd, mag, neg);
    wait_done(tag, cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'(W));
    chk({tag, "_acc"}, 32'(bif.acc_out), 32'(exp_acc));
    chk({tag, "_err"}, 32'(bif.range_err), 32'(exp_err));
    @(negedge clk); bif.out_ready = 1'b1;
    @(posedge clk); #1; bif.out_ready = 1'b0;
    chk({tag, "_ovalid_clr"}, 32'(bif.out_valid), 32'd0);
    chk({tag, "_iready_set"}, 32'(bif.in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [W-1:0] acc, rd, mag;
    logic neg;

    rst = 1'b1;
    bif.in_valid = 1'b0; bif.rd_data = '0; bif.diff_mag = '0;
    bif.diff_neg = 1'b0; bif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_acc", 32'(bif.acc_out), 32'd0);
    chk("rst_err", 32'(bif.range_err), 32'd0);
    @(negedge clk); rst = 1'b0;

    // out_ready outside DONE does nothing
    @(negedge clk); bif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_oready_ovalid", 32'(bif.out_valid), 32'd0);
    chk("idle_oready_iready", 32'(bif.in_ready), 32'd1);
    bif.out_ready = 1'b0;

    op("add_5_3",    8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    op("sub_5_3",    8'h05, 8'h03, 1'b1, 8'h02, 1'b0);
    op("negzero",    8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    op("negzero_a5", 8'hA5, 8'h00, 1'b1, 8'hA5, 1'b0);
    op("ovf_f0_20",  8'hF0, 8'h20, 1'b0, 8'h10, 1'b1);
    op("brw_2_5",    8'h02, 8'h05, 1'b1, 8'hFD, 1'b1);
    op("max_add",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

    // Backpressure with ignored input traffic
    wait_ready("bp");
    launch(8'h33, 8'h11, 1'b0);
    wait_done("bp", cyc);
    chk("bp_latency", 32'(cyc), 32'(W));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bif.in_valid = ~bif.in_valid;
      bif.rd_data  = 8'hC0 + 8'(i);
      bif.diff_mag = 8'h0F;
      bif.diff_neg = 1'(i);
      @(posedge clk); #1;
      chk("bp_ovalid", 32'(bif.out_valid), 32'd1);
      chk("bp_acc", 32'(bif.acc_out), 32'h44);
      chk("bp_err", 32'(bif.range_err), 32'd0);
      chk("bp_iready", 32'(bif.in_ready), 32'd0);
    end
    @(negedge clk); bif.in_valid = 1'b0; bif.out_ready = 1'b1;
    @(posedge clk); #1; bif.out_ready = 1'b0;
    chk("bp_rel_ovalid", 32'(bif.out_valid), 32'd0);
    chk("bp_rel_iready", 32'(bif.in_ready), 32'd1);
    repeat (W + 2) @(posedge clk);
    #1;
    chk("bp_nocap_iready", 32'(bif.in_ready), 32'd1);
    chk("bp_nocap_ovalid", 32'(bif.out_valid), 32'd0);
    chk("bp_hold_acc", 32'(bif.acc_out), 32'h44);

    // Async reset after the RUN edge that leaves cnt=3
    wait_ready("rstmid");
    launch(8'h77, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_ovalid", 32'(bif.out_valid), 32'd0);
    chk("rstmid_acc", 32'(bif.acc_out), 32'd0);
    chk("rstmid_iready", 32'(bif.in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    chk("rstmid_no_result", 32'(bif.out_valid), 32'd0);
    op("after_rst", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b0);

    // Round trip: sign-magnitude acc - rd, then restore
    for (int i = 0; i < 8; i++) begin
      acc = 8'($urandom_range(0, 255));
      rd  = 8'($urandom_range(0, 255));
      if (acc >= rd) begin mag = acc - rd; neg = 1'b0; end
      else           begin mag = rd - acc; neg = 1'b1; end
      op($sformatf("rt%0d", i), rd, mag, neg, acc, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
